// File: rtl/sram_req_arbiter_pkg.sv
// sram_arb_pkg: shared types for the sram request arbiter
// Holds the FSM state type, master source ids and the in-flight tag record.
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;
  typedef struct packed {
    logic        src;
    logic        wr;
    logic [29:0] waddr;
  } tag_t;
endpackage

// File: rtl/sram_req_arbiter_if.sv
// sram_req_arbiter_if: one sram-like request/response bus
// master: drives req/wr/size/addr/wdata, receives rdata/addr_ok/data_ok.
// slave:  the opposite direction.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;
  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_req_arbiter_tag_fifo.sv
// arb_tag_fifo: in-order tag FIFO of accepted-but-unanswered transactions
// Ports: clk, reset (async), push_i/tag_i enqueue, pop_i dequeue head_o,
// ent_o/vld_o expose every slot for the hazard compare, full_o/empty_o/count_o.
module arb_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  tag_t                           tag_i,
  output tag_t                           head_o,
  output tag_t [DEPTH-1:0]               ent_o,
  output logic [DEPTH-1:0]               vld_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [DEPTH-1:0] vld_q;
  logic [CW-1:0]    count_q;
  tag_t [DEPTH-1:0] mem_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= nxt(wptr_q);
      if (pop_i) rptr_q <= nxt(rptr_q);
      vld_q   <= (vld_q & ~(pop_i ? DEPTH'(1) << rptr_q : '0)) | (push_i ? DEPTH'(1) << wptr_q : '0);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= tag_i;
  end
  assign head_o  = mem_q[rptr_q];
  assign ent_o   = mem_q;
  assign vld_o   = vld_q;
  assign count_o = count_q;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram slave port between inst (m0) and data (m1) masters
// Ports: clk, reset (async), m0_if/m1_if master-facing buses, s_if bridge-facing bus,
// err_unexp_o sticky flag for a completion arriving with nothing in flight.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  sram_req_arbiter_if.slave        m0_if,
  sram_req_arbiter_if.slave        m1_if,
  sram_req_arbiter_if.master       s_if,
  output logic                     err_unexp_o
);
  localparam int CW = $clog2(MAX_OUT+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  state_e             state_q, state_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               err_q;
  tag_t [MAX_OUT-1:0] ent;
  logic [MAX_OUT-1:0] ent_v;
  tag_t               head, push_tag;
  logic               full, empty;
  logic [CW-1:0]      count;
  logic               hit, m0_elig, m1_elig, starved, sel_v, sel_src, push, pop;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_OUT; i++)
      hit = hit | (ent_v[i] && ent[i].wr && ent[i].waddr == m1_if.addr[31:2]);
  end
  // a pop in the same cycle does not free a slot for this cycle's pick
  assign m0_elig = m0_if.req && !full;
  assign m1_elig = m1_if.req && (m1_if.wr || !hit) && !full;
  assign starved = starve_q >= SW'(STARVE_LIMIT);
  // LOCK_x pins the mux so a request already shown to the bridge cannot change
  assign sel_src = state_q == LOCK_D || (state_q == IDLE && m1_elig && !(starved && m0_elig));
  assign sel_v   = !reset && (state_q == LOCK_D ? m1_if.req : state_q == LOCK_I ? m0_if.req : m0_elig || m1_elig);
  assign s_if.req   = sel_v;
  assign s_if.wr    = sel_v && (sel_src ? m1_if.wr : m0_if.wr);
  assign s_if.size  = sel_v ? (sel_src ? m1_if.size : m0_if.size) : '0;
  assign s_if.addr  = sel_v ? (sel_src ? m1_if.addr : m0_if.addr) : '0;
  assign s_if.wdata = sel_v ? (sel_src ? m1_if.wdata : m0_if.wdata) : '0;
  assign push = sel_v && s_if.addr_ok;
  assign pop  = !reset && s_if.data_ok && !empty;
  assign push_tag = '{src: sel_src, wr: s_if.wr, waddr: s_if.addr[31:2]};
  assign m0_if.addr_ok = push && sel_src == SRC_INST;
  assign m1_if.addr_ok = push && sel_src == SRC_DATA;
  assign m0_if.data_ok = pop && head.src == SRC_INST;
  assign m1_if.data_ok = pop && head.src == SRC_DATA;
  assign m0_if.rdata   = reset ? '0 : s_if.rdata;
  assign m1_if.rdata   = reset ? '0 : s_if.rdata;
  assign err_unexp_o   = err_q;
  assign state_d  = (sel_v && !s_if.addr_ok) ? (sel_src == SRC_DATA ? LOCK_D : LOCK_I) : IDLE;
  assign starve_d = (!m0_if.req || m0_if.addr_ok) ? '0 :
                    (m1_if.addr_ok && !starved) ? starve_q + 1'b1 : starve_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_q | (s_if.data_ok && empty);
    end
  end
  arb_tag_fifo #(.DEPTH(MAX_OUT)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .tag_i   (push_tag),
    .head_o  (head),
    .ent_o   (ent),
    .vld_o   (ent_v),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assert property (@(posedge clk) disable iff (reset) full == (count == CW'(MAX_OUT)));
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: table, directed and random checks of sram_req_arbiter against a queue model
module tb_sram_req_arbiter;
  logic clk, reset, err;
  sram_req_arbiter_if m0_if();
  sram_req_arbiter_if m1_if();
  sram_req_arbiter_if s_if();
  sram_req_arbiter #(.MAX_OUT(2), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_if       (m0_if),
    .m1_if       (m1_if),
    .s_if        (s_if),
    .err_unexp_o (err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {bit src; bit wr; bit [29:0] wa;} tb_tag_t;
  typedef struct {bit m0r; bit m1r; bit m1w; bit aok; bit es; logic [31:0] ea; bit e0; bit e1;} vec_t;
  tb_tag_t q[$];
  int starve, lockm, n_pass, n_tot;
  bit err_m;
  vec_t tv[5];
  logic [136:0] obs;
  assign obs = {s_if.req, s_if.wr, s_if.size, s_if.addr, s_if.wdata, m0_if.addr_ok, m1_if.addr_ok,
                m0_if.data_ok, m1_if.data_ok, m0_if.rdata, m1_if.rdata, err};
  function automatic void model_reset();
    q.delete();
    starve = 0;
    lockm = -1;
    err_m = 0;
  endfunction
  function automatic void eval(output logic [136:0] e, output int own);
    bit full, hit, e0, e1, dok, src0;
    logic wr;
    logic [1:0] sz;
    logic [31:0] a, wd, rd;
    full = q.size() >= 2;
    hit = 0;
    foreach (q[i]) if (q[i].wr && q[i].wa == m1_if.addr[31:2]) hit = 1;
    e0 = m0_if.req && !full;
    e1 = m1_if.req && (m1_if.wr || !hit) && !full;
    if (reset) own = -1;
    else if (lockm == 0) own = m0_if.req ? 0 : -1;
    else if (lockm == 1) own = m1_if.req ? 1 : -1;
    else if (starve >= 4 && e0) own = 0;
    else if (e1) own = 1;
    else if (e0) own = 0;
    else own = -1;
    wr = own == 1 ? m1_if.wr : own == 0 ? m0_if.wr : 1'b0;
    sz = own == 1 ? m1_if.size : own == 0 ? m0_if.size : 2'b0;
    a  = own == 1 ? m1_if.addr : own == 0 ? m0_if.addr : 32'b0;
    wd = own == 1 ? m1_if.wdata : own == 0 ? m0_if.wdata : 32'b0;
    dok = !reset && s_if.data_ok && q.size() > 0;
    src0 = q.size() > 0 ? q[0].src : 1'b0;
    rd = reset ? 32'b0 : s_if.rdata;
    e = {own >= 0, wr, sz, a, wd, own == 0 && s_if.addr_ok, own == 1 && s_if.addr_ok,
         dok && !src0, dok && src0, rd, rd, err_m};
  endfunction
  function automatic void update();
    logic [136:0] e;
    int own;
    bit acc;
    tb_tag_t t;
    eval(e, own);
    if (reset) begin
      model_reset();
      return;
    end
    acc = own >= 0 && s_if.addr_ok;
    if (s_if.data_ok) begin
      if (q.size() > 0) void'(q.pop_front());
      else err_m = 1;
    end
    if (acc) begin
      t.src = own == 1;
      t.wr  = own == 1 ? m1_if.wr : m0_if.wr;
      t.wa  = own == 1 ? m1_if.addr[31:2] : m0_if.addr[31:2];
      q.push_back(t);
    end
    starve = (!m0_if.req || (acc && own == 0)) ? 0 : (acc && own == 1 && starve < 4) ? starve + 1 : starve;
    lockm = (own >= 0 && !s_if.addr_ok) ? own : -1;
  endfunction
  task automatic chk(input string nm, input logic [136:0] got, input logic [136:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask
  task automatic cyc(input string nm);
    logic [136:0] e;
    int own;
    @(negedge clk);
    eval(e, own);
    chk(nm, obs, e);
  endtask
  task automatic adv();
    update();
    @(posedge clk);
    #1;
  endtask
  task automatic set_m(input int w, input bit r, input bit wr, input logic [31:0] a);
    if (w == 0) begin
      m0_if.req = r; m0_if.wr = wr; m0_if.addr = a; m0_if.wdata = ~a; m0_if.size = 2'd2;
    end else begin
      m1_if.req = r; m1_if.wr = wr; m1_if.addr = a; m1_if.wdata = ~a; m1_if.size = 2'd2;
    end
  endtask
  task automatic rnd_m(input int w);
    logic [31:0] a;
    a = 32'h100 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
    set_m(w, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a);
    if (w == 0) m0_if.size = 2'($urandom_range(0, 2));
    else m1_if.size = 2'($urandom_range(0, 2));
  endtask
  task automatic idle();
    set_m(0, 0, 0, 0);
    set_m(1, 0, 0, 0);
    s_if.addr_ok = 0;
    s_if.data_ok = 0;
    s_if.rdata = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask
  initial begin
    n_pass = 0;
    n_tot = 0;
    tv[0] = '{1, 1, 0, 1, 1, 32'h2000, 0, 1};
    tv[1] = '{1, 0, 0, 1, 1, 32'h1000, 1, 0};
    tv[2] = '{0, 1, 1, 0, 1, 32'h2000, 0, 0};
    tv[3] = '{0, 0, 0, 1, 0, 32'h0, 0, 0};
    tv[4] = '{1, 1, 1, 0, 1, 32'h2000, 0, 0};
    do_reset();
    cyc("rst_model");
    chk("rst_outputs_zero", obs, '0);
    adv();
    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_m(0, tv[i].m0r, 0, 32'h1000);
      set_m(1, tv[i].m1r, tv[i].m1w, 32'h2000);
      s_if.addr_ok = tv[i].aok;
      cyc($sformatf("tbl%0d_model", i));
      chk($sformatf("tbl%0d", i), {s_if.req, s_if.addr, m0_if.addr_ok, m1_if.addr_ok},
          {tv[i].es, tv[i].ea, tv[i].e0, tv[i].e1});
      adv();
    end
    do_reset();
    set_m(0, 1, 0, 32'h1000);
    set_m(1, 1, 0, 32'h2000);
    s_if.addr_ok = 1;
    cyc("t1_pick");
    chk("t1_addr_ok", {m0_if.addr_ok, m1_if.addr_ok}, 2'b01);
    adv();
    idle();
    s_if.data_ok = 1;
    s_if.rdata = 32'hCAFE_0001;
    cyc("t1_resp");
    chk("t1_tag_src", {m0_if.data_ok, m1_if.data_ok, m1_if.rdata}, {2'b01, 32'hCAFE_0001});
    adv();
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      set_m(0, 1, 0, 32'h1000);
      set_m(1, 1, 0, 32'h200);
      s_if.addr_ok = 1;
      s_if.data_ok = c >= 2;
      s_if.rdata = 32'(32'hD000 + c);
      cyc($sformatf("t2_c%0d_model", c));
      chk($sformatf("t2_c%0d_grant", c), {m0_if.addr_ok, m1_if.addr_ok}, c == 5 ? 2'b10 : 2'b01);
      if (c == 6) chk("t2_m0_dok", {m0_if.data_ok, m1_if.data_ok}, 2'b10);
      adv();
    end
    do_reset();
    set_m(1, 1, 1, 32'h100);
    s_if.addr_ok = 1;
    cyc("t3_wr");
    chk("t3_wr_acc", m1_if.addr_ok, 1);
    adv();
    for (int c = 0; c < 2; c++) begin
      set_m(1, 1, 0, 32'h102);
      cyc("t3_blk_model");
      chk($sformatf("t3_blocked%0d", c), s_if.req, 0);
      adv();
    end
    set_m(1, 1, 0, 32'h104);
    cyc("t3_other_model");
    chk("t3_other_word", {s_if.req, m1_if.addr_ok}, 2'b11);
    adv();
    set_m(1, 1, 0, 32'h102);
    s_if.data_ok = 1;
    cyc("t3_pop_model");
    chk("t3_pop_cycle_blocked", {s_if.req, m1_if.data_ok}, 2'b01);
    adv();
    cyc("t3_go_model");
    chk("t3_after_wr_done", {s_if.req, m1_if.addr_ok}, 2'b11);
    adv();
    do_reset();
    set_m(0, 1, 0, 32'h300);
    s_if.addr_ok = 1;
    for (int c = 0; c < 2; c++) begin
      cyc("t4_acc_model");
      chk($sformatf("t4_acc%0d", c), m0_if.addr_ok, 1);
      adv();
    end
    cyc("t4_full_model");
    chk("t4_full_blocks", s_if.req, 0);
    adv();
    s_if.data_ok = 1;
    cyc("t4_pop_model");
    chk("t4_pop_not_credited", {s_if.req, m0_if.data_ok}, 2'b01);
    adv();
    s_if.data_ok = 0;
    cyc("t4_next_model");
    chk("t4_issue_after_pop", {s_if.req, m0_if.addr_ok}, 2'b11);
    adv();
    do_reset();
    set_m(0, 1, 0, 32'h400);
    cyc("t5_show");
    adv();
    set_m(1, 1, 0, 32'h500);
    for (int c = 0; c < 2; c++) begin
      cyc("t5_lock_model");
      chk($sformatf("t5_lock_i%0d", c), {s_if.req, s_if.addr}, {1'b1, 32'h400});
      adv();
    end
    s_if.addr_ok = 1;
    cyc("t5_acc_model");
    chk("t5_acc", {s_if.addr, m0_if.addr_ok, m1_if.addr_ok}, {32'h400, 2'b10});
    adv();
    s_if.addr_ok = 0;
    set_m(0, 0, 0, 32'h400);
    cyc("t5_d_model");
    chk("t5_m1_shown", s_if.addr, 32'h500);
    adv();
    set_m(1, 0, 0, 32'h500);
    cyc("t5_drop_model");
    chk("t5_drop_in_lock", s_if.req, 0);
    adv();
    do_reset();
    s_if.data_ok = 1;
    cyc("t6_unexp_model");
    chk("t6_no_dok", {m0_if.data_ok, m1_if.data_ok}, 2'b00);
    adv();
    s_if.data_ok = 0;
    cyc("t6_err_model");
    chk("t6_err_sticky", err, 1);
    adv();
    set_m(0, 1, 0, 32'h600);
    set_m(1, 1, 1, 32'h700);
    s_if.addr_ok = 1;
    s_if.rdata = 32'h1234_5678;
    cyc("t6_b0");
    adv();
    s_if.addr_ok = 0;
    cyc("t6_b1");
    adv();
    #2;
    reset = 1;
    model_reset();
    #1;
    chk("t6_async_zero", obs, '0);
    @(posedge clk);
    #1;
    reset = 0;
    idle();
    cyc("t6_after_rst");
    adv();
    for (int n = 0; n < 400; n++) begin
      if (lockm != 0) rnd_m(0);
      else if ($urandom_range(0, 7) == 0) m0_if.req = 0;
      if (lockm != 1) rnd_m(1);
      else if ($urandom_range(0, 7) == 0) m1_if.req = 0;
      s_if.addr_ok = $urandom_range(0, 2) != 0;
      s_if.data_ok = q.size() > 0 && $urandom_range(0, 1) == 1;
      s_if.rdata = $urandom();
      cyc($sformatf("rand%0d", n));
      adv();
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
